// File: rtl/ias_pkg.sv
// Shared types for the ias accumulator core: opcode and FSM state enums plus decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ias_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMP   = 4'h5,
    OP_JZ    = 4'h6,
    OP_JC    = 4'h7,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_W,
    S_DECODE,
    S_OPER,
    S_HALT
  } state_t;

  // Map the raw opcode field onto the enum; unassigned encodings collapse to NOP
  // so the FSM never has to reason about them.
  function automatic opcode_t decode_opc(input logic [OPC_W-1:0] field);
    case (field)
      4'h1:    return OP_LOAD;
      4'h2:    return OP_STORE;
      4'h3:    return OP_ADD;
      4'h4:    return OP_SUB;
      4'h5:    return OP_JMP;
      4'h6:    return OP_JZ;
      4'h7:    return OP_JC;
      4'hF:    return OP_HALT;
      default: return OP_NOP;
    endcase
  endfunction

  // Instructions that need a second memory access (operand read) before completing.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ias_mem.sv
// Single-port instruction/data RAM with registered read (read-before-write on collision).
// Latency: rdata valid one clk after addr is presented; write lands on the same edge.
// Backpressure: none; accepts one access every cycle.
// Ports: clk; we/addr/wdata write+address port; rdata registered read data.
module ias_mem
  import ias_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset: program contents survive core reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ias_core_p.sv
// Parametrised fetch/decode/execute accumulator core owning its RAM; IDLE/HALT accept program loads.
// Latency: LOAD/ADD/SUB 4 cycles, other instructions 3 cycles; halted rises the cycle after HALT decodes.
// Backpressure: none; prog_we is silently dropped while busy=1.
// Ports: clk, reset (sync, active-high); start; prog_we/prog_addr/prog_wdata load port;
//        ac_out, pc_out, busy, halted, carry status. Optional macro IAS_CARRY_EN enables the
//        carry flag and JC; without it carry is tied 0 and JC is a NOP. Requires DATA_W >= ADDR_W+4.
module ias_core_p
  import ias_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              carry
);

  state_t            state, state_n;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [ADDR_W-1:0] pc;
  opcode_t           opc;
  logic [ADDR_W-1:0] operand;

  logic              fsm_we;
  logic [ADDR_W-1:0] fsm_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign opc     = decode_opc(ir[DATA_W-1 -: OPC_W]);
  assign operand = ir[ADDR_W-1:0];

  // Bits between the opcode and operand fields carry no meaning.
  localparam int IGN_W = DATA_W - OPC_W - ADDR_W;
  generate
    if (IGN_W > 0) begin : g_ign
      logic ir_unused;
      assign ir_unused = ^ir[DATA_W-OPC_W-1:ADDR_W];
    end
  endgenerate

`ifdef IAS_CARRY_EN
  logic carry_q;
  assign carry = carry_q;
`else
  assign carry = 1'b0;
`endif

  // State register plus registered status decodes (glitch-free busy/halted).
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      busy   <= (state_n != S_IDLE) && (state_n != S_HALT);
      halted <= (state_n == S_HALT);
    end
  end

  always_comb begin
    state_n  = state;
    fsm_we   = 1'b0;
    fsm_addr = pc;
    case (state)
      S_IDLE:    if (start) state_n = S_FETCH;
      S_FETCH:   state_n = S_FETCH_W;
      S_FETCH_W: state_n = S_DECODE;
      S_DECODE: begin
        fsm_addr = operand;
        if (is_mem_op(opc)) begin
          state_n = S_OPER;
        end else if (opc == OP_HALT) begin
          state_n = S_HALT;
        end else begin
          fsm_we  = (opc == OP_STORE);
          state_n = S_FETCH;
        end
      end
      S_OPER:    state_n = S_FETCH;
      S_HALT:    if (start) state_n = S_FETCH;
      default:   state_n = S_IDLE;
    endcase
  end

  // The load port owns the RAM whenever the core is parked; reset blocks every write,
  // including a STORE caught in DECODE.
  assign mem_we    = !reset && (busy ? fsm_we : prog_we);
  assign mem_addr  = busy ? fsm_addr : prog_addr;
  assign mem_wdata = busy ? ac : prog_wdata;

  ias_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ac <= '0;
      ir <= '0;
`ifdef IAS_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_HALT: if (start) pc <= '0;
        S_FETCH_W: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          case (opc)
            OP_JMP: pc <= operand;
            OP_JZ:  if (ac == '0) pc <= operand;
`ifdef IAS_CARRY_EN
            OP_JC:  if (carry_q) pc <= operand;
`endif
            default: ;
          endcase
        end
        S_OPER: begin
          case (opc)
            OP_LOAD: ac <= mem_rdata;
`ifdef IAS_CARRY_EN
            // The extra MSB of the widened sum/difference is carry-out / borrow.
            OP_ADD:  {carry_q, ac} <= {1'b0, ac} + {1'b0, mem_rdata};
            OP_SUB:  {carry_q, ac} <= {1'b0, ac} - {1'b0, mem_rdata};
`else
            OP_ADD:  ac <= ac + mem_rdata;
            OP_SUB:  ac <= ac - mem_rdata;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign ac_out = ac;
  assign pc_out = pc;

endmodule

// File: tb/tb_ias_core_p.sv
module tb_ias_core_p;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_wdata = '0;
  logic [15:0] ac_out;
  logic [7:0]  pc_out;
  logic        busy, halted, carry;

  ias_core_p #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .ac_out(ac_out), .pc_out(pc_out), .busy(busy), .halted(halted), .carry(carry)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  // Tracks the architectural state and how many cycles of the current instruction
  // have elapsed: PC advances after its 2nd cycle, branches/stores/HALT resolve after
  // the 3rd, memory-operand instructions update AC after the 4th.
  logic [15:0] m_mem [256];
  logic [15:0] m_ir = '0;
  logic [15:0] m_ac = '0;
  logic [7:0]  m_pc = '0;
  logic        m_c = 1'b0;
  logic        m_run = 1'b0;
  logic        m_halt = 1'b0;
  int          m_k = 0;
  logic [16:0] m_sum;
  logic [7:0]  m_a;

  always @(posedge clk) begin
    cyc++;
    m_a = m_ir[7:0];
    if (reset) begin
      m_pc = '0; m_ac = '0; m_ir = '0; m_c = 1'b0;
      m_run = 1'b0; m_halt = 1'b0; m_k = 0;
    end else if (!m_run) begin
      if (prog_we) m_mem[prog_addr] = prog_wdata;
      if (start) begin
        if (m_halt) m_pc = '0;
        m_run = 1'b1; m_halt = 1'b0; m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == 2) begin
        m_ir = m_mem[m_pc];
        m_pc = m_pc + 8'd1;
      end else if (m_k == 3) begin
        m_k = 0;
        case (m_ir[15:12])
          4'h1, 4'h3, 4'h4: m_k = 3;
          4'h2: m_mem[m_a] = m_ac;
          4'h5: m_pc = m_a;
          4'h6: if (m_ac == 16'h0) m_pc = m_a;
          4'h7: if (m_c) m_pc = m_a;
          4'hF: begin m_run = 1'b0; m_halt = 1'b1; end
          default: ;
        endcase
      end else if (m_k == 4) begin
        m_k = 0;
        case (m_ir[15:12])
          4'h1: m_ac = m_mem[m_a];
          4'h3: begin
            m_sum = {1'b0, m_ac} + {1'b0, m_mem[m_a]};
`ifdef IAS_CARRY_EN
            m_c = m_sum[16];
`endif
            m_ac = m_sum[15:0];
          end
          4'h4: begin
`ifdef IAS_CARRY_EN
            m_c = (m_mem[m_a] > m_ac);
`endif
            m_ac = m_ac - m_mem[m_a];
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ac_out", 32'(ac_out), 32'(m_ac));
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("busy",   32'(busy),   32'(m_run));
      check("halted", 32'(halted), 32'(m_halt));
      check("carry",  32'(carry),  32'(m_c));
    end
  end

  // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Edges counted from (and excluding) the edge that sampled start.
  task automatic wait_halt(input int max_e, output int edges, output bit wrapped);
    logic [7:0] prev;
    prev = pc_out;
    wrapped = 0;
    while (halted !== 1'b1 && (cyc - t0) < max_e) begin
      @(negedge clk);
      if (prev == 8'hFF && pc_out == 8'h00) wrapped = 1;
      prev = pc_out;
    end
    edges = cyc - t0;
    if (halted !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL halt_timeout: no halt within %0d edges", max_e);
    end
  endtask

  int e;
  bit w;
  logic [15:0] exp_c;
  logic [7:0]  exp_jc_pc;

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1;

    // Reset state
    check("rst_ac", 32'(ac_out), 32'h0);
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);

    // Basic run: LOAD 16, ADD 17, STORE 18, HALT
    prog(8'h00, 16'h1010); prog(8'h01, 16'h3011); prog(8'h02, 16'h2012);
    prog(8'h03, 16'hF000); prog(8'h10, 16'd5);    prog(8'h11, 16'd7);
    start_pulse();
    wait_halt(60, e, w);
    check("basic_edges", 32'(e), 32'd14);
    check("basic_ac", 32'(ac_out), 32'd12);
    check("basic_pc", 32'(pc_out), 32'd4);
    prog(8'h00, 16'h1012); prog(8'h01, 16'hF000);
    start_pulse();
    wait_halt(40, e, w);
    check("readback_edges", 32'(e), 32'd7);
    check("readback_ac", 32'(ac_out), 32'd12);

    // SUB wrap and JC
    prog(8'h00, 16'h1010); prog(8'h01, 16'h4011); prog(8'h02, 16'h7020);
    prog(8'h03, 16'hF000); prog(8'h10, 16'd3);    prog(8'h11, 16'd5);
    prog(8'h20, 16'hF000);
    start_pulse();
    wait_halt(60, e, w);
`ifdef IAS_CARRY_EN
    exp_c = 16'd1; exp_jc_pc = 8'h21;
`else
    exp_c = 16'd0; exp_jc_pc = 8'h04;
`endif
    check("sub_edges", 32'(e), 32'd14);
    check("sub_ac", 32'(ac_out), 32'hFFFE);
    check("sub_carry", 32'(carry), 32'(exp_c));
    check("jc_pc", 32'(pc_out), 32'(exp_jc_pc));

    // JZ countdown: 3 iterations of SUB/JZ/JMP
    prog(8'h00, 16'h1010); prog(8'h01, 16'h4011); prog(8'h02, 16'h6004);
    prog(8'h03, 16'h5001); prog(8'h04, 16'hF000); prog(8'h10, 16'd3);
    prog(8'h11, 16'd1);
    start_pulse();
    wait_halt(100, e, w);
    check("jz_edges", 32'(e), 32'd34);
    check("jz_ac", 32'(ac_out), 32'd0);
    check("jz_pc", 32'(pc_out), 32'd5);

    // prog_we while busy is dropped
    prog(8'h40, 16'h0777); prog(8'h00, 16'h1040); prog(8'h01, 16'h3040);
    prog(8'h02, 16'hF000);
    start_pulse();
    @(negedge clk);
    prog(8'h40, 16'hBEEF);
    wait_halt(60, e, w);
    check("busywr_edges", 32'(e), 32'd11);
    check("busywr_ac", 32'(ac_out), 32'h0EEE);
    prog(8'h00, 16'h1040); prog(8'h01, 16'hF000);
    start_pulse();
    wait_halt(40, e, w);
    check("busywr_mem", 32'(ac_out), 32'h0777);

    // prog_we together with start in IDLE: new M[0] runs first
    prog(8'h00, 16'hF000); prog(8'h01, 16'hF000); prog(8'h41, 16'h0ABC);
    do_reset();
    prog_we = 1'b1; prog_addr = 8'h00; prog_wdata = 16'h1041;
    start_pulse();
    prog_we = 1'b0;
    wait_halt(40, e, w);
    check("pws_edges", 32'(e), 32'd7);
    check("pws_ac", 32'(ac_out), 32'h0ABC);

    // Reset during the DECODE cycle of STORE 0x30
    prog(8'h30, 16'h1234); prog(8'h10, 16'h0055); prog(8'h00, 16'h1010);
    prog(8'h01, 16'h2030); prog(8'h02, 16'hF000);
    start_pulse();
    while ((cyc - t0) < 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstst_ac", 32'(ac_out), 32'h0);
    check("rstst_pc", 32'(pc_out), 32'h0);
    check("rstst_busy", 32'(busy), 32'h0);
    check("rstst_halted", 32'(halted), 32'h0);
    check("rstst_carry", 32'(carry), 32'h0);
    prog(8'h00, 16'h1030); prog(8'h01, 16'hF000);
    start_pulse();
    wait_halt(40, e, w);
    check("rstst_mem", 32'(ac_out), 32'h1234);

    // PC wrap: program rewrites M[0] to HALT, jumps to 0xFF, NOP wraps PC to 0
    prog(8'h00, 16'h5010); prog(8'h10, 16'h1020); prog(8'h11, 16'h2000);
    prog(8'h12, 16'h50FF); prog(8'hFF, 16'h0000); prog(8'h20, 16'hF000);
    start_pulse();
    wait_halt(80, e, w);
    check("wrap_seen", 32'(w), 32'd1);
    check("wrap_edges", 32'(e), 32'd19);
    check("wrap_pc", 32'(pc_out), 32'd1);
    check("wrap_ac", 32'(ac_out), 32'hF000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
